// File: rtl/pio_pixel_position_pkg.sv
// Shared register map and bit positions for the pixel-position output PIO.
package pio_pixel_position_pkg;

   localparam logic [1:0] ADDR_DATA    = 2'd0;
   localparam logic [1:0] ADDR_STATUS  = 2'd1;
   localparam logic [1:0] ADDR_CONTROL = 2'd2;
   localparam logic [1:0] ADDR_CLEAR   = 2'd3;

   localparam int ST_EMPTY   = 0;
   localparam int ST_FULL    = 1;
   localparam int ST_OVF     = 2;
   localparam int ST_LVL_LSB = 8;

   localparam int CT_EN    = 0;
   localparam int CT_FLUSH = 1;
   localparam int CT_IRQEN = 2;

endpackage

// File: rtl/pio_pixel_sync_fifo.sv
// Show-ahead synchronous FIFO. The caller qualifies push/pop: push only when
// not full (or together with a pop), pop only when not empty. Flush wins over
// any push/pop in the same cycle.
module pio_pixel_sync_fifo #(
   parameter int DEPTH  = 4,
   parameter int DATA_W = 32
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     flush,
   input  logic [DATA_W-1:0]        wdata,
   output logic [DATA_W-1:0]        head,
   output logic                     empty,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic [AW:0]       count;

   // Storage, pointers (wrapping naturally at a power-of-two depth) and occupancy.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= wdata;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)      count <= count + 1'b1;
         else if (pop && !push) count <= count - 1'b1;
      end
   end

   assign head  = mem[rd_ptr];
   assign empty = (count == '0);
   assign full  = (count == (AW+1)'(DEPTH));
   assign level = count;

endmodule

// File: rtl/pio_pixel_position_out.sv
// Avalon-MM write-side PIO: software pushes packed pixel positions
// (x in [15:0], y in [31:16]) into a FIFO drained over a valid/ready stream.
// Optional feature macro: PIO_PIXEL_POSITION_OUT_IRQ_EN adds CONTROL.irq_en
// and a registered, level-sensitive "FIFO empty" interrupt on port irq.
module pio_pixel_position_out
   import pio_pixel_position_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [1:0]        address,
   input  logic              chipselect,
   input  logic              write,
   input  logic [DATA_W-1:0] writedata,
   output logic [DATA_W-1:0] readdata,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready
`ifdef PIO_PIXEL_POSITION_OUT_IRQ_EN
   ,
   output logic              irq
`endif
);

   localparam int LW = $clog2(DEPTH) + 1;

   logic              enable;
   logic              overflow;
   logic [DATA_W-1:0] last_written;
   logic              empty;
   logic              full;
   logic [LW-1:0]     level;
   logic              wr_cs;
   logic              push_req;
   logic              push_ok;
   logic              pop;
   logic              flush;
   logic              ctl_wr;
   logic              clr_wr;
   logic [DATA_W-1:0] rd_mux;
`ifdef PIO_PIXEL_POSITION_OUT_IRQ_EN
   logic              irq_en;
`endif

   assign wr_cs    = chipselect & write;
   assign push_req = wr_cs & (address == ADDR_DATA);
   assign ctl_wr   = wr_cs & (address == ADDR_CONTROL);
   assign clr_wr   = wr_cs & (address == ADDR_CLEAR);
   assign flush    = ctl_wr & writedata[CT_FLUSH];
   assign out_valid = enable & ~empty;
   assign pop       = out_valid & out_ready;
   // A pop in the same cycle frees a slot, so a push into a full FIFO is still taken.
   assign push_ok  = push_req & (~full | pop);

   pio_pixel_sync_fifo #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push_ok),
      .pop   (pop),
      .flush (flush),
      .wdata (writedata),
      .head  (out_data),
      .empty (empty),
      .full  (full),
      .level (level)
   );

   // Register read mux, sampled into readdata every cycle regardless of read strobe.
   always_comb begin
      rd_mux = '0;
      case (address)
         ADDR_DATA:    rd_mux = last_written;
         ADDR_STATUS: begin
            rd_mux[ST_EMPTY]          = empty;
            rd_mux[ST_FULL]           = full;
            rd_mux[ST_OVF]            = overflow;
            rd_mux[ST_LVL_LSB +: LW]  = level;
         end
         ADDR_CONTROL: begin
            rd_mux[CT_EN] = enable;
`ifdef PIO_PIXEL_POSITION_OUT_IRQ_EN
            rd_mux[CT_IRQEN] = irq_en;
`endif
         end
         default:      rd_mux = '0;
      endcase
   end

   // Register file state, sticky overflow and registered read data.
   always_ff @(posedge clk) begin
      if (reset) begin
         enable       <= 1'b0;
         overflow     <= 1'b0;
         last_written <= '0;
         readdata     <= '0;
`ifdef PIO_PIXEL_POSITION_OUT_IRQ_EN
         irq_en       <= 1'b0;
         irq          <= 1'b0;
`endif
      end else begin
         readdata <= rd_mux;
         if (ctl_wr) enable <= writedata[CT_EN];
         if (clr_wr)                   overflow <= 1'b0;
         else if (push_req && !push_ok) overflow <= 1'b1;
         if (push_ok) last_written <= writedata;
`ifdef PIO_PIXEL_POSITION_OUT_IRQ_EN
         if (ctl_wr) irq_en <= writedata[CT_IRQEN];
         irq <= irq_en & empty;
`endif
      end
   end

endmodule

// File: tb/tb_pio_pixel_position_out.sv
// Directed bench for pio_pixel_position_out (DEPTH=4, DATA_W=32).
module tb_pio_pixel_position_out;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [1:0]  address = 2'd0;
   logic        chipselect = 1'b0;
   logic        write = 1'b0;
   logic [31:0] writedata = '0;
   logic [31:0] readdata;
   logic [31:0] out_data;
   logic        out_valid;
   logic        out_ready = 1'b0;
`ifdef PIO_PIXEL_POSITION_OUT_IRQ_EN
   logic        irq;
`endif

   logic [31:0] exp_q [$];
   logic [31:0] mon_exp;
   logic [31:0] w [0:6];
   int          n_assert = 0;
   int          n_fail = 0;
   int          guard;

   always #5 clk = ~clk;

   pio_pixel_position_out #(.DEPTH(4), .DATA_W(32)) dut (
      .clk        (clk),
      .reset      (reset),
      .address    (address),
      .chipselect (chipselect),
      .write      (write),
      .writedata  (writedata),
      .readdata   (readdata),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready)
`ifdef PIO_PIXEL_POSITION_OUT_IRQ_EN
      ,
      .irq        (irq)
`endif
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
      address    = a;
      writedata  = d;
      chipselect = 1'b1;
      write      = 1'b1;
      tick();
      chipselect = 1'b0;
      write      = 1'b0;
   endtask

   task automatic push_word(input logic [31:0] d, input bit accepted);
      bus_write(2'd0, d);
      if (accepted) exp_q.push_back(d);
   endtask

   task automatic rd_check(input string tag, input logic [1:0] a, input logic [31:0] exp);
      address = a;
      tick();
      check(tag, readdata, exp);
   endtask

   // Stream monitor: every handshake must deliver the oldest expected word.
   always @(negedge clk) begin
      if (!reset && out_valid && out_ready) begin
         n_assert++;
         assert (exp_q.size() != 0) else begin
            n_fail++;
            $error("FAIL pop_unexpected observed=0x%08h expected=none", out_data);
         end
         if (exp_q.size() != 0) begin
            mon_exp = exp_q.pop_front();
            check("pop_order", out_data, mon_exp);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "bench timed out");
   end

   initial begin
      w[0] = 32'h0001_0002; w[1] = 32'h0003_0004; w[2] = 32'h0005_0006;
      w[3] = 32'h0007_0008; w[4] = 32'h0009_000A; w[5] = 32'h1111_2222;
      w[6] = 32'h3333_4444;

      // Reset state
      repeat (3) tick();
      check("rst_readdata", readdata, 32'h0);
      check("rst_out_valid", {31'b0, out_valid}, 32'h0);
      reset = 1'b0;
      rd_check("rst_status", 2'd1, 32'h0000_0001);
      rd_check("rst_control", 2'd2, 32'h0);
      rd_check("rst_data", 2'd0, 32'h0);

      // Single word through an enabled stream
      bus_write(2'd2, 32'h1);
      out_ready = 1'b1;
      push_word(32'h00F0_0140, 1'b1);
      check("single_valid", {31'b0, out_valid}, 32'h1);
      check("single_data", out_data, 32'h00F0_0140);
      tick();
      rd_check("single_status", 2'd1, 32'h0000_0001);
      check("single_drained", exp_q.size(), 32'h0);
      out_ready = 1'b0;

      // Overflow with the stream disabled
      bus_write(2'd2, 32'h0);
      for (int i = 0; i < 5; i++) push_word(w[i], i < 4);
      check("dis_out_valid", {31'b0, out_valid}, 32'h0);
      check("dis_head", out_data, w[0]);
      rd_check("ovf_status", 2'd1, 32'h0000_0406);
      rd_check("ovf_last_written", 2'd0, w[3]);
      bus_write(2'd3, 32'h0);
      rd_check("clr_status", 2'd1, 32'h0000_0402);

      // Push into a full FIFO while popping
      bus_write(2'd2, 32'h1);
      check("en_out_valid", {31'b0, out_valid}, 32'h1);
      out_ready = 1'b1;
      push_word(32'hAAAA_5555, 1'b1);
      out_ready = 1'b0;
      rd_check("pushpop_status", 2'd1, 32'h0000_0402);
      out_ready = 1'b1;
      guard = 0;
      while (exp_q.size() != 0 && guard < 20) begin
         tick();
         guard++;
      end
      check("drain_done", exp_q.size(), 32'h0);
      out_ready = 1'b0;
      check("drain_out_valid", {31'b0, out_valid}, 32'h0);
      rd_check("drain_status", 2'd1, 32'h0000_0001);

      // Back-pressure hold, then flush during a pop
      push_word(w[5], 1'b1);
      push_word(w[6], 1'b1);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("hold_data", out_data, w[5]);
         check("hold_valid", {31'b0, out_valid}, 32'h1);
      end
      out_ready = 1'b1;
      bus_write(2'd2, 32'h3);
      out_ready = 1'b0;
      exp_q.delete();
      check("flush_out_valid", {31'b0, out_valid}, 32'h0);
      rd_check("flush_status", 2'd1, 32'h0000_0001);
      rd_check("flush_control", 2'd2, 32'h0000_0001);
      rd_check("flush_last_written", 2'd0, w[6]);

`ifdef PIO_PIXEL_POSITION_OUT_IRQ_EN
      bus_write(2'd2, 32'h5);
      tick();
      check("irq_empty", {31'b0, irq}, 32'h1);
      rd_check("irq_en_readback", 2'd2, 32'h0000_0005);
      push_word(32'h0BAD_F00D, 1'b1);
      check("irq_after_push", {31'b0, irq}, 32'h1);
      tick();
      check("irq_cleared", {31'b0, irq}, 32'h0);
`else
      bus_write(2'd2, 32'h5);
      rd_check("ctl_bit2_ignored", 2'd2, 32'h0000_0001);
      push_word(32'h0BAD_F00D, 1'b1);
`endif

      // Reset mid-stream with a push in flight
      reset      = 1'b1;
      address    = 2'd0;
      writedata  = 32'h1234_5678;
      chipselect = 1'b1;
      write      = 1'b1;
      tick();
      chipselect = 1'b0;
      write      = 1'b0;
      check("midrst_out_valid", {31'b0, out_valid}, 32'h0);
      check("midrst_readdata", readdata, 32'h0);
`ifdef PIO_PIXEL_POSITION_OUT_IRQ_EN
      check("midrst_irq", {31'b0, irq}, 32'h0);
`endif
      reset = 1'b0;
      exp_q.delete();
      rd_check("midrst_status", 2'd1, 32'h0000_0001);
      rd_check("midrst_data", 2'd0, 32'h0);
      rd_check("midrst_control", 2'd2, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/pio_pixel_position_out.md
Name: pio_pixel_position_out

Overview:
- Avalon-MM write-side PIO: the NIOS II writes packed pixel positions (x in [15:0], y in [31:16]) into a small FIFO.
- The FIFO drains over a valid/ready stream toward the sprite/VGA drawing logic.
- It is the output-direction counterpart of the pixel-position input PIO.
- It decouples software write timing from frame-rate consumption.

Parameters:
- DEPTH, 4, FIFO entries; power of two, 2..16.
- DATA_W, 32, width of the position word and of writedata/readdata.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- address  in  2  Avalon register select.
- chipselect  in  1  Avalon slave select.
- write  in  1  Avalon write strobe; qualified by chipselect.
- writedata  in  DATA_W  Avalon write data.
- readdata  out  DATA_W  registered Avalon read data.
- out_data  out  DATA_W  FIFO head word (show-ahead).
- out_valid  out  1  out_data is valid.
- out_ready  in  1  consumer accepts the word.
- irq  out  1  interrupt; present only with the optional feature.

Behaviour:
- One clock (clk); reset is synchronous and active-high.
- Reset values: FIFO empty, level 0, overflow 0, enable 0, last_written 0, readdata 0, out_valid 0, irq 0.
- Register map:
  - 0 DATA: write pushes writedata. Read returns last_written (the last accepted word).
  - 1 STATUS (RO): bit0 empty, bit1 full, bit2 overflow (sticky), bits[12:8] level, rest 0.
  - 2 CONTROL: bit0 enable, bit2 irq_en (feature only); other bits read 0. Write bit1=1 is a flush pulse and is not stored.
  - 3 CLEAR: any write clears overflow; reads return 0.
- readdata: registered every cycle as readdata <= mux(address), independent of read strobes. Value is visible the cycle after address is presented (1-cycle read latency, 0 wait states).
- Push: chipselect & write & address==0.
  - Accepted if not full, or if a pop occurs in the same cycle; level is then unchanged on push+pop.
  - Otherwise the word is dropped, overflow is set, and last_written is not updated.
- Pop: out_valid & out_ready.
- out_valid = enable & ~empty. out_data always equals the head word, even when enable=0.
- Handshake: out_data is held stable while out_valid=1 and out_ready=0. Deasserting enable withdraws out_valid without popping.
- Flush (CONTROL write with bit1=1):
  - Next cycle the FIFO is empty and level is 0.
  - Overflow and last_written are unaffected.
  - Flush beats a simultaneous pop; the popped word is discarded.
- Pointers wrap modulo DEPTH. Level is $clog2(DEPTH)+1 bits, zero-extended into STATUS.
- Reset mid-operation clears all state on that edge; an in-flight push or pop in that cycle is lost.

Optional Feature:
- Macro: PIO_PIXEL_POSITION_OUT_IRQ_EN.
- Defined:
  - Adds CONTROL bit2 irq_en and port irq.
  - irq is registered: irq <= irq_en & empty, so it is level-sensitive and clears one cycle after a push makes the FIFO non-empty.
- Undefined:
  - No irq port; CONTROL bit2 reads 0 and ignores writes.

Decomposition:
- Package pio_pixel_position_pkg:
  - Register address constants: ADDR_DATA=0, ADDR_STATUS=1, ADDR_CONTROL=2, ADDR_CLEAR=3.
  - STATUS bit positions: ST_EMPTY=0, ST_FULL=1, ST_OVF=2, ST_LVL_LSB=8.
  - CONTROL bit positions: CT_EN=0, CT_FLUSH=1, CT_IRQEN=2.
- One sub-module, pio_pixel_sync_fifo:
  - Show-ahead synchronous FIFO, parameters DEPTH and DATA_W.
  - Inputs push, pop, flush; outputs head, empty, full, level.
- The top level holds the register file, read mux and handshake.

Test Plan:
- Reset, then read STATUS -> readdata 0x00000001 one cycle later; out_valid=0.
- Enable=1, write DATA 0x00F0_0140, out_ready=1 -> out_valid rises on the next cycle with out_data 0x00F00140; popped; STATUS returns to 0x1.
- Enable=0, write 5 words (DEPTH=4) -> STATUS=0x00000406 (level 4, full, overflow); DATA readback = 4th word; then write CLEAR -> STATUS=0x00000402.
- Full FIFO, enable=1, out_ready=1, push 0xAAAA5555 in the same cycle -> accepted, level stays 4, no overflow; words drain in FIFO order ending with 0xAAAA5555.
- out_valid=1 with out_ready=0 for 3 cycles -> out_data stable; flush write during a pop cycle -> next cycle empty, level 0.
- Feature on: irq_en=1, empty -> irq=1; push -> irq=0 one cycle after the push; assert reset mid-stream -> all outputs 0 on the next edge.
